// File: rtl/pearson_hash_verifier_pkg.sv
// Shared types and the table lookup for the Pearson digest checker.
package pearson_pkg;
    localparam int TABLE_BITS = 2048;
    localparam int HASH_W     = 8;

    typedef enum logic [1:0] {IDLE, ABSORB, COMPARE, DONE} state_t;

    function automatic logic [HASH_W-1:0] lookup(
        input logic [TABLE_BITS-1:0] t,
        input logic [HASH_W-1:0]     idx
    );
        return t[{idx, 3'b000} +: HASH_W];
    endfunction
endpackage

// File: rtl/pearson_hash_verifier_if.sv
// Byte stream carrying the message into the digest checker.
interface pearson_hash_verifier_if;
    import pearson_pkg::*;

    logic              byte_valid;
    logic              byte_ready;
    logic              byte_last;
    logic [HASH_W-1:0] byte_data;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready
    );
endinterface

// File: rtl/pearson_hash_verifier_round.sv
// One Pearson round: next digest = T[h ^ b]; shared with the hash generator.
module pearson_round
    import pearson_pkg::*;
(
    input  logic [TABLE_BITS-1:0] random_table,
    input  logic [HASH_W-1:0]     h,
    input  logic [HASH_W-1:0]     b,
    output logic [HASH_W-1:0]     h_next
);
    assign h_next = lookup(random_table, h ^ b);
endmodule

// File: rtl/pearson_hash_verifier.sv
// Streaming Pearson digest checker; PEARSON_VERIFY_TIMEOUT_EN adds an idle-stream watchdog.
module pearson_hash_verifier
    import pearson_pkg::*;
#(
    parameter int              MSG_MAX_BYTES  = 32,
    parameter logic [HASH_W-1:0] INIT_HASH    = 8'h00,
    parameter int              TIMEOUT_CYCLES = 255,
    localparam int             CW = $clog2(MSG_MAX_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [HASH_W-1:0]       expected_hash,
    input  logic [TABLE_BITS-1:0]   random_table,
    pearson_hash_verifier_if.slave  stream,
    output logic                    busy,
    output logic                    done,
    output logic                    match,
    output logic                    error,
    output logic [HASH_W-1:0]       computed_hash,
    output logic [CW-1:0]           byte_count
);
    state_t            state, state_n;
    logic [HASH_W-1:0] h, h_n, h_round;
    logic [HASH_W-1:0] exp_q, exp_n;
    logic [HASH_W-1:0] hash_q, hash_n;
    logic [CW-1:0]     count, count_n, count_inc;
    logic              match_q, match_n;
    logic              error_q, error_n;
    logic              xfer;
    logic              timeout;

    pearson_round u_round (
        .random_table (random_table),
        .h            (h),
        .b            (stream.byte_data),
        .h_next       (h_round)
    );

    assign xfer      = (state == ABSORB) && stream.byte_valid;
    assign count_inc = count + CW'(1);

`ifdef PEARSON_VERIFY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != ABSORB || stream.byte_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive empty ABSORB cycle.
    assign timeout = (state == ABSORB) && !stream.byte_valid &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    wire unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        h_n     = h;
        count_n = count;
        exp_n   = exp_q;
        hash_n  = hash_q;
        match_n = match_q;
        error_n = error_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ABSORB;
                    exp_n   = expected_hash;
                    h_n     = INIT_HASH;
                    count_n = '0;
                    match_n = 1'b0;
                    error_n = 1'b0;
                end
            end
            ABSORB: begin
                if (xfer) begin
                    h_n = h_round;
                    if (count != CW'(MSG_MAX_BYTES))
                        count_n = count_inc;
                    if (stream.byte_last) begin
                        state_n = COMPARE;
                    end else if (count_inc == CW'(MSG_MAX_BYTES)) begin
                        error_n = 1'b1;
                        match_n = 1'b0;
                        hash_n  = h_round;
                        state_n = DONE;
                    end
                end else if (timeout) begin
                    error_n = 1'b1;
                    match_n = 1'b0;
                    hash_n  = h;
                    state_n = DONE;
                end
            end
            COMPARE: begin
                match_n = (h == exp_q);
                hash_n  = h;
                state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            h       <= INIT_HASH;
            count   <= '0;
            exp_q   <= '0;
            hash_q  <= INIT_HASH;
            match_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_n;
            h       <= h_n;
            count   <= count_n;
            exp_q   <= exp_n;
            hash_q  <= hash_n;
            match_q <= match_n;
            error_q <= error_n;
        end
    end

    assign stream.byte_ready = (state == ABSORB);
    assign busy          = (state == ABSORB) || (state == COMPARE);
    assign done          = (state == DONE);
    assign match         = match_q;
    assign error         = error_q;
    assign computed_hash = hash_q;
    assign byte_count    = count;
endmodule

// File: tb/tb_pearson_hash_verifier.sv
// Directed bench for pearson_hash_verifier (MSG_MAX_BYTES=4, TIMEOUT_CYCLES=8).
module tb_pearson_hash_verifier;
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    expected_hash;
    logic [2047:0] random_table;
    logic          busy, done, match, error;
    logic [7:0]    computed_hash;
    logic [2:0]    byte_count;
    logic [2047:0] tbl_id, tbl_inv;
    int            vectors = 0;
    int            miscompares = 0;

    pearson_hash_verifier_if s ();

    pearson_hash_verifier #(
        .MSG_MAX_BYTES  (4),
        .INIT_HASH      (8'h00),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .expected_hash (expected_hash),
        .random_table  (random_table),
        .stream        (s.slave),
        .busy          (busy),
        .done          (done),
        .match         (match),
        .error         (error),
        .computed_hash (computed_hash),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    task automatic start_msg(input logic [7:0] e);
        expected_hash = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        s.byte_valid = 1'b1;
        s.byte_data  = d;
        s.byte_last  = l;
        n = 0;
        while (s.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL handshake: byte_ready never high for byte %h", d);
        end
        @(negedge clk);
        s.byte_valid = 1'b0;
        s.byte_last  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, match, error, s.byte_ready} !== 5'b0 ||
            computed_hash !== 8'h00 || byte_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset: got b%b d%b m%b e%b r%b h%h c%0d want zeros h00 c0",
                     busy, done, match, error, s.byte_ready, computed_hash, byte_count);
        end
    endtask

    // Finishes a message whose last byte was just sent: COMPARE then DONE.
    task automatic finish_msg(input string name, input logic m,
                              input logic [7:0] hh, input logic [2:0] c);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_compare: got done=%b busy=%b want 0 1", name, done, busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || match !== m || error !== 1'b0 ||
            computed_hash !== hh || byte_count !== c) begin
            miscompares++;
            $display("FAIL %s_done: got d%b m%b e%b h%h c%0d want d1 m%b e0 h%h c%0d",
                     name, done, match, error, computed_hash, byte_count, m, hh, c);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || match !== m) begin
            miscompares++;
            $display("FAIL %s_after: got d%b b%b m%b want d0 b0 m%b",
                     name, done, busy, match, m);
        end
    endtask

    task automatic test_match();
        random_table = tbl_id;
        start_msg(8'h26);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        finish_msg("match", 1'b1, 8'h26, 3'd2);
    endtask

    task automatic test_mismatch();
        random_table = tbl_id;
        start_msg(8'h27);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        finish_msg("mismatch", 1'b0, 8'h26, 3'd2);
    endtask

    task automatic test_invert();
        random_table = tbl_inv;
        start_msg(8'h0F);
        send_byte(8'h00, 1'b0);
        send_byte(8'h0F, 1'b1);
        finish_msg("invert", 1'b1, 8'h0F, 3'd2);
    endtask

    task automatic test_max_len();
        random_table = tbl_id;
        start_msg(8'h0F);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h08, 1'b1);
        finish_msg("maxlen", 1'b1, 8'h0F, 3'd4);
    endtask

    task automatic test_overlength();
        random_table = tbl_id;
        start_msg(8'h00);
        vectors++;
        if (match !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_clear: got m%b b%b want m0 b1", match, busy);
        end
        for (int i = 1; i <= 4; i++)
            send_byte(8'(i), 1'b0);
        s.byte_valid = 1'b1;
        s.byte_data  = 8'h05;
        #1;
        vectors++;
        if (done !== 1'b1 || error !== 1'b1 || match !== 1'b0 ||
            s.byte_ready !== 1'b0 || byte_count !== 3'd4) begin
            miscompares++;
            $display("FAIL overlength: got d%b e%b m%b r%b c%0d want d1 e1 m0 r0 c4",
                     done, error, match, s.byte_ready, byte_count);
        end
        @(negedge clk);
        vectors++;
        if (s.byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL overlength_idle: got r%b b%b d%b e%b want r0 b0 d0 e1",
                     s.byte_ready, busy, done, error);
        end
        s.byte_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        random_table = tbl_id;
        start_msg(8'h26);
        send_byte(8'h12, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall: got b%b d%b want b1 d0", busy, done);
        end
        send_byte(8'h34, 1'b1);
        finish_msg("gaps", 1'b1, 8'h26, 3'd2);
    endtask

    task automatic test_reset_mid();
        int seen;
        random_table = tbl_id;
        start_msg(8'h00);
        send_byte(8'h55, 1'b0);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        vectors++;
        if ({busy, done, match, error, s.byte_ready} !== 5'b0 ||
            computed_hash !== 8'h00 || byte_count !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset: got b%b d%b m%b e%b r%b h%h c%0d want zeros h00 c0",
                     busy, done, match, error, s.byte_ready, computed_hash, byte_count);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d active cycles want 0", seen);
        end
        test_invert();
    endtask

`ifdef PEARSON_VERIFY_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        random_table = tbl_id;
        start_msg(8'h00);
        send_byte(8'h12, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 8 || error !== 1'b1 || match !== 1'b0 || computed_hash !== 8'h12) begin
            miscompares++;
            $display("FAIL timeout: got n%0d e%b m%b h%h want n8 e1 m0 h12",
                     n, error, match, computed_hash);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbl_id[8*i +: 8]  = 8'(i);
            tbl_inv[8*i +: 8] = ~8'(i);
        end
        reset         = 1'b1;
        start         = 1'b0;
        expected_hash = 8'h00;
        random_table  = tbl_id;
        s.byte_valid  = 1'b0;
        s.byte_data   = 8'h00;
        s.byte_last   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_match();
        test_mismatch();
        test_invert();
        test_max_len();
        test_overlength();
        test_backpressure();
        test_reset_mid();
`ifdef PEARSON_VERIFY_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
